// File: rtl/fsm_seq_arbiter_if.sv
// Client/detector-side bundle of the shared-detector round-robin scheduler.
// The slave modport is the scheduler; the master modport is the environment
// (requesters, result consumer and the detector instance).
interface fsm_seq_arbiter_if #(
    parameter int NREQ    = 4,
    parameter int FRAME_W = 8,
    parameter int IDW     = $clog2(NREQ),
    parameter int CNTW    = $clog2(FRAME_W + 1)
);
    logic [NREQ-1:0]         req_i;
    logic [NREQ*FRAME_W-1:0] frame_i;
    logic [NREQ-1:0]         ack_o;
    logic                    det_clr_o;
    logic                    det_x_o;
    logic                    det_outp_i;
    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [IDW-1:0]          rsp_id_o;
    logic [CNTW-1:0]         rsp_cnt_o;
    logic                    rsp_hit_o;
    logic                    busy_o;

    modport slave (
        input  req_i, frame_i, det_outp_i, rsp_ready_i,
        output ack_o, det_clr_o, det_x_o, rsp_valid_o, rsp_id_o,
               rsp_cnt_o, rsp_hit_o, busy_o
    );

    modport master (
        output req_i, frame_i, det_outp_i, rsp_ready_i,
        input  ack_o, det_clr_o, det_x_o, rsp_valid_o, rsp_id_o,
               rsp_cnt_o, rsp_hit_o, busy_o
    );
endinterface

// File: rtl/fsm_seq_arbiter.sv
// Round-robin scheduler sharing one bit-serial detector between NREQ
// requesters. Each granted frame is run through the detector MSB-first after a
// one-cycle clear, the detector's output pulses are counted, and the count is
// returned tagged with the requester id.
module fsm_seq_arbiter #(
    parameter int NREQ    = 4,
    parameter int FRAME_W = 8,
    parameter int IDW     = $clog2(NREQ),
    parameter int CNTW    = $clog2(FRAME_W + 1)
) (
    input  logic              clk,
    input  logic              reset,   // asynchronous, active low
    fsm_seq_arbiter_if.slave  bus
);
    localparam int KW = $clog2(FRAME_W);
    localparam logic [KW-1:0] K_LAST = KW'(FRAME_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_id;
    logic [FRAME_W-1:0]  r_shift;
    logic [KW-1:0]       r_k;
    logic [CNTW-1:0]     r_cnt;

    logic                w_any;
    logic [IDW-1:0]      w_gnt;
    logic [IDW-1:0]      w_idx;
    logic                w_det_clr;
    logic                w_det_x;
    logic [FRAME_W-1:0]  w_frames [NREQ];

    // Unpacked view of the flat frame bus so the granted frame is a plain index.
    for (genvar r = 0; r < NREQ; r++) begin : g_frames
        assign w_frames[r] = bus.frame_i[r*FRAME_W +: FRAME_W];
    end

    // Round-robin search: first pending request after the last grant, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned (which would infer a latch).
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = IDW'((int'(r_ptr) + i) % NREQ);
            if (!w_any && bus.req_i[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state detector controls.
    always_comb begin
        w_state_nxt = r_state;
        w_det_clr   = 1'b0;
        w_det_x     = 1'b0;
        unique case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_CLEAR;
            S_CLEAR: begin
                w_det_clr   = 1'b1;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                w_det_x = r_shift[FRAME_W-1];
                if (r_k == K_LAST) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: w_state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture, serialisation and hit counting.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            r_ptr   <= IDW'(NREQ - 1);
            r_id    <= '0;
            r_shift <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ptr   <= w_gnt;
                        r_id    <= w_gnt;
                        r_shift <= w_frames[w_gnt];
                    end
                end
                S_CLEAR: begin
                    r_cnt <= '0;
                    r_k   <= '0;
                end
                S_SHIFT: begin
                    r_shift <= r_shift << 1;
                    r_k     <= r_k + 1'b1;
                    // Detector output is one cycle behind: shift cycle k sees
                    // the response to bit k-1, so cycle 0 has nothing to count.
                    if (r_k != '0 && bus.det_outp_i) r_cnt <= r_cnt + 1'b1;
                end
                S_DRAIN: begin
                    if (bus.det_outp_i) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The ack is combinational in the grant cycle; gating with reset keeps it
    // low while reset is held even if requests are already pending.
    assign bus.ack_o       = (r_state == S_IDLE && w_any && reset)
                             ? (NREQ'(1) << w_gnt) : '0;
    assign bus.det_clr_o   = w_det_clr | ~reset;
    assign bus.det_x_o     = w_det_x;
    assign bus.rsp_valid_o = (r_state == S_RESP);
    assign bus.rsp_id_o    = r_id;
    assign bus.rsp_cnt_o   = r_cnt;
    assign bus.rsp_hit_o   = (r_cnt != '0);
    assign bus.busy_o      = (r_state != S_IDLE);
endmodule

// File: tb/tb_fsm_seq_arbiter.sv
// Bench for fsm_seq_arbiter: directed scenarios followed by random traffic.
// Grants are predicted by a round-robin model, results by popcount of the
// granted frame (the detector stub echoes det_x one cycle late).
module tb_fsm_seq_arbiter;
    localparam int NREQ    = 4;
    localparam int FRAME_W = 8;
    localparam int IDW     = $clog2(NREQ);
    localparam int CNTW    = $clog2(FRAME_W + 1);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fsm_seq_arbiter_if #(.NREQ(NREQ), .FRAME_W(FRAME_W)) bus ();

    fsm_seq_arbiter #(.NREQ(NREQ), .FRAME_W(FRAME_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stimulus-driven inputs.
    logic [NREQ-1:0]    req_drv = '0;
    logic [FRAME_W-1:0] frm [NREQ];
    logic               ready_drv = 1'b1;

    assign bus.req_i       = req_drv;
    assign bus.rsp_ready_i = ready_drv;
    always_comb begin
        bus.frame_i = '0;
        for (int r = 0; r < NREQ; r++) bus.frame_i[r*FRAME_W +: FRAME_W] = frm[r];
    end

    // Detector stub: register of det_x, cleared by det_clr.
    logic r_det;
    always @(posedge clk) r_det <= bus.det_clr_o ? 1'b0 : bus.det_x_o;
    assign bus.det_outp_i = r_det;

    // Scoreboard and reference state.
    typedef struct {
        int id;
        int cnt;
    } exp_t;
    exp_t exp_q [$];
    int   ack_g_q [$];
    int   ack_c_q [$];
    int   model_ptr = NREQ - 1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_ack_cyc = 0;
    bit   mon_en = 1'b0;
    bit   prev_valid = 1'b0;
    bit   prev_accept = 1'b0;
    bit   acked [NREQ];
    logic [IDW-1:0]  held_id;
    logic [CNTW-1:0] held_cnt;
    logic            held_hit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round-robin reference: first requester after ptr, wrapping; -1 if none.
    function automatic int rr_pick(input logic [NREQ-1:0] req, input int ptr);
        for (int i = 1; i <= NREQ; i++) begin
            if (req[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    // Monitor: predicts at each ack, compares at each accepted response.
    always @(negedge clk) begin
        int   g;
        exp_t e;
        cyc++;
        if (mon_en) begin
            if (bus.ack_o != '0) begin
                g = rr_pick(req_drv, model_ptr);
                check("ack_grant", 32'(bus.ack_o), (g < 0) ? 32'd0 : (32'd1 << g));
                check("ack_while_busy", 32'(bus.busy_o), 32'd0);
                if (g >= 0) begin
                    e.id  = g;
                    e.cnt = $countones(frm[g]);
                    exp_q.push_back(e);
                    model_ptr = g;
                    ack_g_q.push_back(g);
                    ack_c_q.push_back(cyc);
                    last_ack_cyc = cyc;
                    acked[g] = 1'b1;
                end
            end
            if (bus.rsp_valid_o && !prev_valid)
                check("rsp_latency", 32'(cyc - last_ack_cyc), 32'(FRAME_W + 3));
            if (bus.rsp_valid_o && prev_valid && !prev_accept) begin
                check("hold_id", 32'(bus.rsp_id_o), 32'(held_id));
                check("hold_cnt", 32'(bus.rsp_cnt_o), 32'(held_cnt));
                check("hold_hit", 32'(bus.rsp_hit_o), 32'(held_hit));
            end
            if (bus.rsp_valid_o && ready_drv) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", 32'(bus.rsp_id_o), 32'(e.id));
                    check("rsp_cnt", 32'(bus.rsp_cnt_o), 32'(e.cnt));
                    check("rsp_hit", 32'(bus.rsp_hit_o), (e.cnt != 0) ? 32'd1 : 32'd0);
                end
            end
            prev_valid  = bus.rsp_valid_o;
            prev_accept = bus.rsp_valid_o && ready_drv;
            held_id     = bus.rsp_id_o;
            held_cnt    = bus.rsp_cnt_o;
            held_hit    = bus.rsp_hit_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_det_clr"}, 32'(bus.det_clr_o), 32'd1);
        check({tag, "_det_x"}, 32'(bus.det_x_o), 32'd0);
        check({tag, "_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        check({tag, "_ack"}, 32'(bus.ack_o), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        check({tag, "_id"}, 32'(bus.rsp_id_o), 32'd0);
        check({tag, "_cnt"}, 32'(bus.rsp_cnt_o), 32'd0);
        check({tag, "_hit"}, 32'(bus.rsp_hit_o), 32'd0);
    endtask

    task automatic reset_assert();
        reset = 1'b0;
        mon_en = 1'b0;
        exp_q.delete();
        ack_g_q.delete();
        ack_c_q.delete();
        model_ptr = NREQ - 1;
        prev_valid = 1'b0;
        prev_accept = 1'b0;
        for (int r = 0; r < NREQ; r++) acked[r] = 1'b0;
    endtask

    task automatic reset_release(input int cycles);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check("rst_hold_det_clr", 32'(bus.det_clr_o), 32'd1);
        tick();
        reset = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic wait_ack(input int r, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.ack_o[r]) got = 1'b1;
        end
        check("ack_arrives", 32'(got), 32'd1);
    endtask

    // Present one frame from requester r, drop the request after its ack.
    task automatic send(input int r, input logic [FRAME_W-1:0] f, input int budget);
        frm[r] = f;
        req_drv[r] = 1'b1;
        wait_ack(r, budget);
        tick();
        req_drv[r] = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!bus.busy_o && !bus.rsp_valid_o && exp_q.size() == 0) done = 1'b1;
        end
        check("drain_done", 32'(done), 32'd1);
        tick();
    endtask

    initial begin
        logic [FRAME_W-1:0] pat;
        bit seen;
        for (int r = 0; r < NREQ; r++) begin
            frm[r] = '0;
            acked[r] = 1'b0;
        end

        // 1: reset values, then a single A5 frame from requester 0.
        reset_assert();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset_release(0);
        pat = 8'hA5;
        frm[0] = pat;
        req_drv[0] = 1'b1;
        wait_ack(0, 20);
        tick();
        req_drv[0] = 1'b0;
        @(negedge clk);
        check("clear_det_clr", 32'(bus.det_clr_o), 32'd1);
        check("clear_det_x", 32'(bus.det_x_o), 32'd0);
        for (int k = 0; k < FRAME_W; k++) begin
            @(negedge clk);
            check("shift_det_x", 32'(bus.det_x_o), 32'(pat[FRAME_W-1-k]));
            check("shift_det_clr", 32'(bus.det_clr_o), 32'd0);
        end
        wait_quiet(40);

        // 2: empty and full frames.
        send(0, 8'h00, 20);
        wait_quiet(40);
        send(0, 8'hFF, 20);
        wait_quiet(40);

        // 3: all requesters held, order 0,1,2,3,0 at FRAME_W+4 spacing.
        reset_assert();
        reset_release(2);
        for (int r = 0; r < NREQ; r++) frm[r] = FRAME_W'($urandom);
        req_drv = '1;
        ready_drv = 1'b1;
        for (int i = 0; i < 100 && ack_g_q.size() < 5; i++) @(negedge clk);
        check("rr_five_acks", 32'(ack_g_q.size() >= 5), 32'd1);
        tick();
        req_drv = '0;
        for (int i = 0; i < 5 && i < ack_g_q.size(); i++) begin
            check("rr_order", 32'(ack_g_q[i]), 32'(i % NREQ));
            if (i > 0) check("rr_spacing", 32'(ack_c_q[i] - ack_c_q[i-1]), 32'(FRAME_W + 4));
        end
        wait_quiet(40);

        // 4: backpressure in RESP, pending request waits for the next IDLE.
        ready_drv = 1'b0;
        send(2, FRAME_W'($urandom), 20);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) seen = 1'b1;
        end
        check("bp_valid_seen", 32'(seen), 32'd1);
        tick();
        frm[0] = FRAME_W'($urandom);
        req_drv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.rsp_valid_o), 32'd1);
            check("bp_busy", 32'(bus.busy_o), 32'd1);
            check("bp_no_ack", 32'(bus.ack_o), 32'd0);
        end
        tick();
        ready_drv = 1'b1;
        @(negedge clk);
        check("bp_last_resp_ack", 32'(bus.ack_o), 32'd0);
        @(negedge clk);
        check("bp_grant_next_idle", 32'(bus.ack_o), 32'd1);
        tick();
        req_drv[0] = 1'b0;
        wait_quiet(40);

        // 5: reset during SHIFT k=3 aborts the frame.
        send(1, FRAME_W'($urandom), 20);
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(bus.busy_o), 32'd1);
        #2;
        reset_assert();
        #1;
        check_reset_outputs("abort");
        reset_release(2);
        seen = 1'b0;
        for (int i = 0; i < FRAME_W + 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o || bus.busy_o) seen = 1'b1;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        tick();

        // 6: ptr=1 after granting 1; requests 0 and 1 -> 0 wins (wrap).
        send(1, FRAME_W'($urandom), 20);
        wait_quiet(40);
        frm[0] = FRAME_W'($urandom);
        frm[1] = FRAME_W'($urandom);
        req_drv[1:0] = 2'b11;
        wait_ack(0, 20);
        check("wrap_grant0", 32'(bus.ack_o), 32'd1);
        tick();
        req_drv[0] = 1'b0;
        wait_ack(1, 30);
        tick();
        req_drv[1] = 1'b0;
        wait_quiet(40);

        // Random traffic with random backpressure.
        for (int r = 0; r < NREQ; r++) acked[r] = 1'b0;
        repeat (3000) begin
            tick();
            ready_drv = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < NREQ; r++) begin
                if (acked[r]) begin
                    acked[r] = 1'b0;
                    if ($urandom_range(0, 1) == 1) frm[r] = FRAME_W'($urandom);
                    else req_drv[r] = 1'b0;
                end else if (!req_drv[r] && $urandom_range(0, 7) == 0) begin
                    frm[r] = FRAME_W'($urandom);
                    req_drv[r] = 1'b1;
                end
            end
        end
        req_drv = '0;
        ready_drv = 1'b1;
        wait_quiet(200);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
